// File: rtl/rom_vector_sequencer_pkg.sv
// Shared defaults and state encoding for the ROM vector sequencer and its address counter.
package rom_vector_sequencer_pkg;

    localparam int W_DEFAULT  = 32;
    localparam int AW_DEFAULT = 10;
    localparam int ROM_DEPTH  = 1 << AW_DEFAULT;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/rom_addr_counter.sv
// Loadable wrapping ROM address counter; holds the inclusive end address and flags when it is reached.
module rom_addr_counter #(
    parameter int AW = rom_vector_sequencer_pkg::AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          inc,
    input  logic [AW-1:0] load_first,
    input  logic [AW-1:0] load_last,
    output logic [AW-1:0] addr,
    output logic          at_last
);

    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] last_q, last_d;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        addr_d = addr_q;
        last_d = last_q;
        if (load) begin
            addr_d = load_first;
            last_d = load_last;
        end else if (inc) begin
            addr_d = addr_q + AW'(1);   // natural wrap from 2^AW-1 to 0
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            last_q <= '0;
        end else begin
            addr_q <= addr_d;
            last_q <= last_d;
        end
    end

    assign addr    = addr_q;
    assign at_last = (addr_q == last_q);

endmodule

// File: rtl/rom_vector_sequencer.sv
// Walks an inclusive, wrapping address range of an external combinational ROM and presents
// each word as a registered valid/ready vector, pulsing done after the last one is accepted.
module rom_vector_sequencer
    import rom_vector_sequencer_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
    output logic [AW-1:0] rom_addr,
    input  logic [W-1:0]  rom_data,
    output logic [W-1:0]  vec_data,
    output logic          vec_valid,
    input  logic          vec_ready,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   vec_count
);

    state_e        state_q, state_d;
    logic [W-1:0]  vec_data_q, vec_data_d;
    logic          vec_valid_q, vec_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW:0]   vec_count_q, vec_count_d;
    logic          addr_load, addr_inc, at_last;

    rom_addr_counter #(.AW(AW)) u_addr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (addr_load),
        .inc        (addr_inc),
        .load_first (first_addr),
        .load_last  (last_addr),
        .addr       (rom_addr),
        .at_last    (at_last)
    );

    always_comb begin
        state_d     = state_q;
        vec_data_d  = vec_data_q;
        vec_valid_d = vec_valid_q;
        vec_count_d = vec_count_q;
        done_d      = 1'b0;
        addr_load   = 1'b0;
        addr_inc    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    addr_load   = 1'b1;
                    vec_count_d = '0;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                vec_data_d  = rom_data;
                vec_valid_d = 1'b1;
                state_d     = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (vec_valid_q && vec_ready) begin
                    vec_valid_d = 1'b0;
                    vec_count_d = vec_count_q + (AW+1)'(1);
                    if (at_last) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        addr_inc = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides whatever the active state decided, including a same-cycle handshake.
        if (abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            vec_valid_d = 1'b0;
            vec_count_d = vec_count_q;
            done_d      = 1'b0;
            addr_inc    = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vec_data_q  <= '0;
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_data_q  <= vec_data_d;
            vec_valid_q <= vec_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vec_count_q <= vec_count_d;
        end
    end

    assign vec_data  = vec_data_q;
    assign vec_valid = vec_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign vec_count = vec_count_q;

endmodule

// File: tb/tb_rom_vector_sequencer.sv
// Directed bench for rom_vector_sequencer; the ROM model returns {rom_pat, rom_addr}.
module tb_rom_vector_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [9:0]  first_addr;
    logic [9:0]  last_addr;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] vec_data;
    logic        vec_valid;
    logic        vec_ready;
    logic        busy;
    logic        done;
    logic [10:0] vec_count;

    logic [21:0] rom_pat;
    logic [31:0] got_q[$];
    int          total;
    int          bad;

    assign rom_data = {rom_pat, rom_addr};

    rom_vector_sequencer #(.W(32), .AW(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .vec_data   (vec_data),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .busy       (busy),
        .done       (done),
        .vec_count  (vec_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int a);
        logic [9:0] a10;
        a10 = 10'(a);
        return {rom_pat, a10};
    endfunction

    // Start is presented for exactly one rising edge; the ranges are then scrambled to prove
    // they were sampled only at acceptance.
    task automatic start_seq(input int f, input int l);
        first_addr = 10'(f);
        last_addr  = 10'(l);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        first_addr = ~10'(f);
        last_addr  = ~10'(l);
    endtask

    // Samples at each falling edge; done_cyc counts rising edges after the start edge.
    task automatic collect(input int budget, output int done_cyc);
        got_q.delete();
        done_cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = c;
                break;
            end
            if (vec_valid && vec_ready) got_q.push_back(vec_data);
        end
    endtask

    task automatic run_seq(input string tag, input int f, input int l, input int n);
        int dc;
        int errs;
        start_seq(f, l);
        collect(2 * n + 20, dc);
        check({tag, "_done_edge"}, 32'(dc + 1), 32'(2 * n + 1));
        check({tag, "_nvec"}, 32'(got_q.size()), 32'(n));
        errs = 0;
        if (got_q.size() == n) begin
            for (int i = 0; i < n; i++) begin
                if (got_q[i] !== exp_word(f + i)) errs++;
            end
        end
        check({tag, "_data_errs"}, 32'(errs), 32'd0);
        check({tag, "_count"}, 32'(vec_count), 32'(n));
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        vec_ready  = 1'b0;
        rom_pat    = 22'h2A5A5A;

        #1;
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_vec_data", vec_data, 32'd0);
        check("rst_valid", 32'(vec_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(vec_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // 5..8 with ready high: one vector every two edges.
        vec_ready = 1'b1;
        start_seq(5, 8);
        check("s1_fetch_addr", 32'(rom_addr), 32'd5);
        check("s1_fetch_busy", 32'(busy), 32'd1);
        check("s1_fetch_valid", 32'(vec_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("s1_valid_%0d", k), 32'(vec_valid), 32'd1);
            check($sformatf("s1_data_%0d", k), vec_data, exp_word(5 + k));
            check($sformatf("s1_addr_%0d", k), 32'(rom_addr), 32'(5 + k));
            check($sformatf("s1_nodone_%0d", k), 32'(done), 32'd0);
            @(negedge clk);
            check($sformatf("s1_gap_%0d", k), 32'(vec_valid), 32'd0);
            if (k < 3) check($sformatf("s1_next_addr_%0d", k), 32'(rom_addr), 32'(6 + k));
            else       check("s1_done", 32'(done), 32'd1);
        end
        check("s1_count", 32'(vec_count), 32'd4);
        @(negedge clk);
        check("s1_done_gone", 32'(done), 32'd0);
        check("s1_idle", 32'(busy), 32'd0);

        // Wrapping range with ROM word equal to address.
        rom_pat = 22'h0;
        run_seq("wrap", 1022, 1, 4);

        // Single vector with back-pressure; a start during PRESENT is ignored.
        rom_pat   = 22'h13579;
        vec_ready = 1'b0;
        start_seq(300, 300);
        @(negedge clk);
        check("bp_valid", 32'(vec_valid), 32'd1);
        check("bp_data", vec_data, exp_word(300));
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                first_addr = 10'd7;
                last_addr  = 10'd9;
                start      = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            check($sformatf("bp_hold_valid_%0d", i), 32'(vec_valid), 32'd1);
            check($sformatf("bp_hold_data_%0d", i), vec_data, exp_word(300));
        end
        check("bp_addr", 32'(rom_addr), 32'd300);
        vec_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_clr", 32'(vec_valid), 32'd0);
        check("bp_done", 32'(done), 32'd1);
        check("bp_count", 32'(vec_count), 32'd1);
        @(negedge clk);
        check("bp_idle", 32'(busy), 32'd0);
        check("bp_done_gone", 32'(done), 32'd0);

        // Abort while presenting the third vector, with a handshake pending in that same cycle.
        rom_pat = 22'h0F0F0;
        start_seq(10, 20);
        repeat (4) @(negedge clk);
        @(negedge clk);
        check("ab_present_valid", 32'(vec_valid), 32'd1);
        check("ab_present_count", 32'(vec_count), 32'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_valid", 32'(vec_valid), 32'd0);
        check("ab_nodone", 32'(done), 32'd0);
        check("ab_count", 32'(vec_count), 32'd2);
        @(negedge clk);
        check("ab_nodone_late", 32'(done), 32'd0);
        first_addr = 10'd3;
        last_addr  = 10'd4;
        start      = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("sa_busy_late", 32'(busy), 32'd0);
        check("sa_count", 32'(vec_count), 32'd2);

        // Full ROM sweep: 1024 vectors, done visible after the 2049th edge counting the start edge.
        rom_pat = 22'h3C3C3;
        run_seq("full", 0, 1023, 1024);

        // Asynchronous reset between clock edges, then a clean restart.
        start_seq(100, 200);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_rom_addr", 32'(rom_addr), 32'd0);
        check("ar_vec_data", vec_data, 32'd0);
        check("ar_valid", 32'(vec_valid), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        check("ar_count", 32'(vec_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("ar_waits", 32'(busy), 32'd0);
        run_seq("post_rst", 50, 51, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_vector_sequencer.md
ROM_VECTOR_SEQUENCER -- requirements
Module: rom_vector_sequencer

Interface
REQ-001 Parameter W, default 32, ROM word width and vector width.
REQ-002 Parameter AW, default 10, ROM address width (1024 words).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a sequence; honoured only in IDLE.
REQ-006 abort  input  1  terminate the sequence in progress.
REQ-007 first_addr  input  AW  first ROM address; sampled on accepted start.
REQ-008 last_addr  input  AW  last ROM address, inclusive; sampled on accepted start.
REQ-009 rom_addr  output  AW  address to the external combinational ROM.
REQ-010 rom_data  input  W  ROM word at rom_addr, valid in the same cycle.
REQ-011 vec_data  output  W  registered vector to the downstream datapath.
REQ-012 vec_valid  output  1  vec_data holds an unconsumed vector.
REQ-013 vec_ready  input  1  downstream accepts vec_data when high together with vec_valid.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse after the last vector is accepted.
REQ-016 vec_count  output  AW+1  number of vectors accepted in the current or most recent sequence.

Function
REQ-017 States: IDLE, FETCH, PRESENT, DONE; registered, one-hot or binary encoding.
REQ-018 IDLE: on start=1 and abort=0, load address register with first_addr, latch last_addr, clear vec_count, enter FETCH.
REQ-019 rom_addr is driven directly from the address register in every state.
REQ-020 FETCH: register rom_data into vec_data, set vec_valid, enter PRESENT; exactly one cycle.
REQ-021 PRESENT: vec_data and vec_valid held stable while vec_ready=0.
REQ-022 PRESENT, handshake (vec_valid and vec_ready both 1): clear vec_valid, increment vec_count; if address equals latched last_addr enter DONE, else increment address and enter FETCH.
REQ-023 Throughput: one vector per two cycles with vec_ready held high; first vec_valid two cycles after the start edge.
REQ-024 Address increment is modulo 2^AW: 1023 wraps to 0.
REQ-025 last_addr < first_addr produces a wrapping sequence (e.g. 1022,1023,0,1).
REQ-026 first_addr == last_addr produces exactly one vector.
REQ-027 DONE: assert done for one cycle, return to IDLE; vec_count retains its final value until the next accepted start.
REQ-028 abort=1 in any non-IDLE state: next state IDLE, vec_valid cleared, no done pulse, vec_count retains its value.
REQ-029 start and abort high together in IDLE: abort wins, no sequence starts.
REQ-030 start outside IDLE is ignored; first_addr and last_addr changes outside an accepted start have no effect.
REQ-031 vec_count saturates at no value; its maximum reachable is 1024, which needs AW+1 bits.

Reset
REQ-032 rst_n low asynchronously forces: state IDLE, address register 0, rom_addr 0, vec_data 0, vec_valid 0, busy 0, done 0, vec_count 0.
REQ-033 Reset mid-sequence discards the sequence; after rst_n deasserts, the block waits for a new start.

Structure
REQ-034 Shared package holds the W and AW defaults, ROM depth constant (1024), and the state encoding constants.
REQ-035 One sub-module, rom_addr_counter: loadable AW-bit wrapping counter with last-address compare output.
REQ-036 The ROM is external; the block contains no storage array.

Verification
REQ-037 first=5, last=8, vec_ready held 1 -> rom_addr 5,6,7,8; four handshakes on alternate cycles; done one cycle after the 4th; vec_count=4.
REQ-038 first=1022, last=1, ROM word = address -> vec_data sequence 1022,1023,0,1; done; vec_count=4.
REQ-039 first=last=300, vec_ready low for 5 cycles after vec_valid -> vec_data stable for 5 cycles, one handshake, done, vec_count=1.
REQ-040 first=0, last=1023, vec_ready=1 -> 1024 vectors, done at cycle 2049 after start, vec_count=1024.
REQ-041 abort in PRESENT after 2 accepted vectors -> IDLE next cycle, vec_valid 0, no done, vec_count=2; start+abort in IDLE -> busy stays 0.
REQ-042 rst_n pulsed low mid-sequence, off the clock edge -> all outputs at reset values immediately; start after release runs a clean sequence.
